bpred_inflight_queue: RTL and testbench

In-order queue that holds every prediction bpredTop issues to fetch until execute resolves the branch. On each resolve it compares the resolved outcome with the stored prediction and drives the predictor's `execute_bpredictor_*` update port. It signals a redirect and flush on a mispredict. It sits between fetch/bpredTop (enqueue side) and the execute-stage branch unit (resolve side).

---
 rtl/bpred_pkg.sv | 16 +
 rtl/bpq_ram.sv | 23 ++
 rtl/bpred_inflight_queue.sv | 135 +++++++++++++
 tb/tb_bpred_inflight_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types and defaults for the branch-prediction in-flight queue.
package bpred_pkg;

   localparam int BPQ_DEPTH_DEFAULT  = 8;
   localparam int BPQ_DATA_W_DEFAULT = 96;
   localparam int BPQ_META_W_DEFAULT = 4;

   typedef struct packed {
      logic [31:0]                   PC4;
      logic                          p_dir;
      logic [31:0]                   p_target;
      logic [BPQ_DATA_W_DEFAULT-1:0] data;
      logic [BPQ_META_W_DEFAULT-1:0] meta;
   } bpq_entry_t;

endpackage

// File: rtl/bpq_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module bpq_ram #(
   parameter int DEPTH = 8,
   parameter int W     = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bpred_inflight_queue.sv
// In-order queue of outstanding predictions; compares against the execute-stage
// resolution, drives the predictor update port and redirects fetch on a mispredict.
module bpred_inflight_queue
   import bpred_pkg::*;
#(
   parameter int DEPTH  = BPQ_DEPTH_DEFAULT,
   parameter int DATA_W = BPQ_DATA_W_DEFAULT,
   parameter int META_W = BPQ_META_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_enq,
   input  logic [31:0]       fetch_enq_PC4,
   input  logic              fetch_enq_p_dir,
   input  logic [31:0]       fetch_enq_p_target,
   input  logic [DATA_W-1:0] fetch_enq_data,
   input  logic [META_W-1:0] fetch_enq_meta,
   output logic              q_full,
   output logic              q_empty,
   input  logic              execute_resolve,
   input  logic              execute_resolve_dir,
   input  logic [31:0]       execute_resolve_target,
   output logic              execute_bpredictor_update,
   output logic [31:0]       execute_bpredictor_PC4,
   output logic [31:0]       execute_bpredictor_target,
   output logic              execute_bpredictor_dir,
   output logic              execute_bpredictor_miss,
   output logic [DATA_W-1:0] execute_bpredictor_data,
   output logic [META_W-1:0] execute_bpredictor_meta,
   output logic              execute_bpredictor_recover_ras,
   output logic              fetch_redirect,
   output logic [31:0]       fetch_redirect_PC,
   output logic              q_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0]       pc4;
      logic              p_dir;
      logic [31:0]       p_target;
      logic [DATA_W-1:0] data;
      logic [META_W-1:0] meta;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   logic [PW-1:0] head, tail, head_nxt, tail_nxt;
   logic [CW-1:0] count, count_nxt;
   entry_t        wr_entry, rd_entry;
   logic          is_empty, is_full;
   logic          do_res, do_enq, miss, flush, err_evt;
   logic [31:0]   redirect_pc;

   assign wr_entry = '{pc4: fetch_enq_PC4, p_dir: fetch_enq_p_dir,
                       p_target: fetch_enq_p_target, data: fetch_enq_data,
                       meta: fetch_enq_meta};

   bpq_ram #(.DEPTH(DEPTH), .W(ENTRY_W), .AW(PW)) u_ram (
      .clk   (clk),
      .we    (do_enq),
      .waddr (tail),
      .wdata (wr_entry),
      .raddr (head),
      .rdata (rd_entry)
   );

   // A mispredict flushes everything younger, including a same-cycle enqueue.
   // When full, a same-cycle non-missing resolve frees the slot being written.
   always_comb begin
      is_empty    = (count == '0);
      is_full     = (count == CW'(DEPTH));
      do_res      = execute_resolve & ~is_empty;
      miss        = (execute_resolve_dir != rd_entry.p_dir) |
                    (execute_resolve_dir & (execute_resolve_target != rd_entry.p_target));
      flush       = do_res & miss;
      do_enq      = fetch_enq & ~flush & (~is_full | do_res);
      err_evt     = (execute_resolve & is_empty) | (fetch_enq & is_full & ~do_res);
      redirect_pc = execute_resolve_dir ? execute_resolve_target : rd_entry.pc4;
      head_nxt    = head;
      tail_nxt    = tail;
      count_nxt   = count;
      if (flush) begin
         head_nxt  = '0;
         tail_nxt  = '0;
         count_nxt = '0;
      end else begin
         head_nxt  = head + PW'(do_res);
         tail_nxt  = tail + PW'(do_enq);
         count_nxt = count + CW'(do_enq) - CW'(do_res);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head                           <= '0;
         tail                           <= '0;
         count                          <= '0;
         q_empty                        <= 1'b1;
         q_full                         <= 1'b0;
         q_err                          <= 1'b0;
         execute_bpredictor_update      <= 1'b0;
         execute_bpredictor_PC4         <= '0;
         execute_bpredictor_target      <= '0;
         execute_bpredictor_dir         <= 1'b0;
         execute_bpredictor_miss        <= 1'b0;
         execute_bpredictor_data        <= '0;
         execute_bpredictor_meta        <= '0;
         execute_bpredictor_recover_ras <= 1'b0;
         fetch_redirect                 <= 1'b0;
         fetch_redirect_PC              <= '0;
      end else begin
         head                           <= head_nxt;
         tail                           <= tail_nxt;
         count                          <= count_nxt;
         q_empty                        <= (count_nxt == '0);
         q_full                         <= (count_nxt == CW'(DEPTH));
         if (err_evt) q_err             <= 1'b1;
         execute_bpredictor_update      <= do_res;
         execute_bpredictor_miss        <= flush;
         execute_bpredictor_recover_ras <= flush;
         fetch_redirect                 <= flush;
         if (do_res) begin
            execute_bpredictor_PC4    <= rd_entry.pc4;
            execute_bpredictor_target <= execute_resolve_target;
            execute_bpredictor_dir    <= execute_resolve_dir;
            execute_bpredictor_data   <= rd_entry.data;
            execute_bpredictor_meta   <= rd_entry.meta;
         end
         if (flush) fetch_redirect_PC <= redirect_pc;
      end
   end

endmodule

// File: tb/tb_bpred_inflight_queue.sv
// Directed, table-driven bench for bpred_inflight_queue; each record is one cycle.
module tb_bpred_inflight_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_enq;
   logic [31:0] fetch_enq_PC4;
   logic        fetch_enq_p_dir;
   logic [31:0] fetch_enq_p_target;
   logic [95:0] fetch_enq_data;
   logic [3:0]  fetch_enq_meta;
   logic        q_full, q_empty, q_err;
   logic        execute_resolve, execute_resolve_dir;
   logic [31:0] execute_resolve_target;
   logic        execute_bpredictor_update, execute_bpredictor_dir;
   logic        execute_bpredictor_miss, execute_bpredictor_recover_ras;
   logic [31:0] execute_bpredictor_PC4, execute_bpredictor_target;
   logic [95:0] execute_bpredictor_data;
   logic [3:0]  execute_bpredictor_meta;
   logic        fetch_redirect;
   logic [31:0] fetch_redirect_PC;

   bpred_inflight_queue #(.DEPTH(8), .DATA_W(96), .META_W(4)) dut (
      .clk                            (clk),
      .reset                          (reset),
      .fetch_enq                      (fetch_enq),
      .fetch_enq_PC4                  (fetch_enq_PC4),
      .fetch_enq_p_dir                (fetch_enq_p_dir),
      .fetch_enq_p_target             (fetch_enq_p_target),
      .fetch_enq_data                 (fetch_enq_data),
      .fetch_enq_meta                 (fetch_enq_meta),
      .q_full                         (q_full),
      .q_empty                        (q_empty),
      .execute_resolve                (execute_resolve),
      .execute_resolve_dir            (execute_resolve_dir),
      .execute_resolve_target         (execute_resolve_target),
      .execute_bpredictor_update      (execute_bpredictor_update),
      .execute_bpredictor_PC4         (execute_bpredictor_PC4),
      .execute_bpredictor_target      (execute_bpredictor_target),
      .execute_bpredictor_dir         (execute_bpredictor_dir),
      .execute_bpredictor_miss        (execute_bpredictor_miss),
      .execute_bpredictor_data        (execute_bpredictor_data),
      .execute_bpredictor_meta        (execute_bpredictor_meta),
      .execute_bpredictor_recover_ras (execute_bpredictor_recover_ras),
      .fetch_redirect                 (fetch_redirect),
      .fetch_redirect_PC              (fetch_redirect_PC),
      .q_err                          (q_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       label;
      bit          rst;
      bit          enq;
      logic [31:0] pc4;
      bit          pdir;
      logic [31:0] ptgt;
      bit          res;
      bit          rdir;
      logic [31:0] rtgt;
      bit          e_upd;
      bit          e_miss;
      logic [31:0] e_pc4;
      bit          e_dir;
      logic [31:0] e_tgt;
      bit          e_redir;
      logic [31:0] e_rpc;
      bit          e_empty;
      bit          e_full;
      bit          e_err;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   function automatic logic [95:0] data_of(logic [31:0] pc4);
      return {pc4 ^ 32'hA5A5_0000, ~pc4, pc4};
   endfunction

   function automatic logic [3:0] meta_of(logic [31:0] pc4);
      return pc4[5:2];
   endfunction

   function automatic vec_t mk(string l, bit en, logic [31:0] pc4, bit pdir, logic [31:0] ptgt,
                               bit rs, bit rdir, logic [31:0] rtgt);
      vec_t v;
      v = '{label: l, rst: 1'b0, enq: en, pc4: pc4, pdir: pdir, ptgt: ptgt, res: rs, rdir: rdir,
            rtgt: rtgt, e_upd: 1'b0, e_miss: 1'b0, e_pc4: '0, e_dir: 1'b0, e_tgt: '0,
            e_redir: 1'b0, e_rpc: '0, e_empty: 1'b0, e_full: 1'b0, e_err: 1'b0};
      return v;
   endfunction

   function automatic vec_t q(vec_t v, bit emp, bit full, bit err);
      vec_t r = v;
      r.e_empty = emp;
      r.e_full  = full;
      r.e_err   = err;
      return r;
   endfunction

   function automatic vec_t u(vec_t v, logic [31:0] pc4, bit dir, logic [31:0] tgt, bit miss);
      vec_t r = v;
      r.e_upd  = 1'b1;
      r.e_pc4  = pc4;
      r.e_dir  = dir;
      r.e_tgt  = tgt;
      r.e_miss = miss;
      return r;
   endfunction

   function automatic vec_t rd(vec_t v, logic [31:0] pc);
      vec_t r = v;
      r.e_redir = 1'b1;
      r.e_rpc   = pc;
      return r;
   endfunction

   function automatic vec_t rst_vec(string l);
      vec_t r = mk(l, 0, 0, 0, 0, 0, 0, 0);
      r.rst = 1'b1;
      return q(r, 1, 0, 0);
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic applyStimulus(input vec_t v);
      reset                  = v.rst;
      fetch_enq              = v.enq;
      fetch_enq_PC4          = v.pc4;
      fetch_enq_p_dir        = v.pdir;
      fetch_enq_p_target     = v.ptgt;
      fetch_enq_data         = data_of(v.pc4);
      fetch_enq_meta         = meta_of(v.pc4);
      execute_resolve        = v.res;
      execute_resolve_dir    = v.rdir;
      execute_resolve_target = v.rtgt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v);
      chk({v.label, ".update"}, execute_bpredictor_update, v.e_upd);
      chk({v.label, ".miss"}, execute_bpredictor_miss, v.e_miss);
      chk({v.label, ".recover_ras"}, execute_bpredictor_recover_ras, v.e_miss);
      chk({v.label, ".redirect"}, fetch_redirect, v.e_redir);
      chk({v.label, ".q_empty"}, q_empty, v.e_empty);
      chk({v.label, ".q_full"}, q_full, v.e_full);
      chk({v.label, ".q_err"}, q_err, v.e_err);
      if (v.e_upd || v.rst) begin
         chk({v.label, ".PC4"}, execute_bpredictor_PC4, v.e_pc4);
         chk({v.label, ".dir"}, execute_bpredictor_dir, v.e_dir);
         chk({v.label, ".target"}, execute_bpredictor_target, v.e_tgt);
         chk({v.label, ".data"}, execute_bpredictor_data, v.e_upd ? data_of(v.e_pc4) : 96'h0);
         chk({v.label, ".meta"}, execute_bpredictor_meta, v.e_upd ? meta_of(v.e_pc4) : 4'h0);
      end
      if (v.e_redir || v.rst) chk({v.label, ".redirect_PC"}, fetch_redirect_PC, v.e_rpc);
   endtask

   initial begin
      // Reset and three correctly predicted branches.
      vecs.push_back(rst_vec("reset0"));
      vecs.push_back(rst_vec("reset1"));
      vecs.push_back(q(mk("a_enq0", 1, 32'h104, 1, 32'h400, 0, 0, 0), 0, 0, 0));
      vecs.push_back(q(mk("a_enq1", 1, 32'h204, 0, 32'h0,   0, 0, 0), 0, 0, 0));
      vecs.push_back(q(mk("a_enq2", 1, 32'h304, 1, 32'h500, 0, 0, 0), 0, 0, 0));
      vecs.push_back(q(u(mk("a_res0", 0, 0, 0, 0, 1, 1, 32'h400), 32'h104, 1, 32'h400, 0), 0, 0, 0));
      vecs.push_back(q(u(mk("a_res1", 0, 0, 0, 0, 1, 0, 32'h999), 32'h204, 0, 32'h999, 0), 0, 0, 0));
      vecs.push_back(q(u(mk("a_res2", 0, 0, 0, 0, 1, 1, 32'h500), 32'h304, 1, 32'h500, 0), 1, 0, 0));
      vecs.push_back(q(mk("a_idle", 0, 0, 0, 0, 0, 0, 0), 1, 0, 0));
      // Direction miss with a same-cycle enqueue that must be discarded.
      vecs.push_back(q(mk("b_enq", 1, 32'h80, 0, 32'h0, 0, 0, 0), 0, 0, 0));
      vecs.push_back(q(rd(u(mk("b_miss", 1, 32'h90, 1, 32'h123, 1, 1, 32'h200),
                            32'h80, 1, 32'h200, 1), 32'h200), 1, 0, 0));
      vecs.push_back(q(mk("b_idle", 0, 0, 0, 0, 0, 0, 0), 1, 0, 0));
      // Target miss, then a taken prediction resolved not-taken (redirect to PC4).
      vecs.push_back(q(mk("c_enq", 1, 32'hA4, 1, 32'h300, 0, 0, 0), 0, 0, 0));
      vecs.push_back(q(rd(u(mk("c_tmiss", 0, 0, 0, 0, 1, 1, 32'h340), 32'hA4, 1, 32'h340, 1), 32'h340), 1, 0, 0));
      vecs.push_back(q(mk("c_enq2", 1, 32'hB4, 1, 32'h600, 0, 0, 0), 0, 0, 0));
      vecs.push_back(q(rd(u(mk("c_ntmiss", 0, 0, 0, 0, 1, 0, 32'h0), 32'hB4, 0, 32'h0, 1), 32'hB4), 1, 0, 0));
      // Fill, overflow, enqueue-while-full with resolve, then drain across the wrap.
      for (int i = 0; i < 8; i++)
         vecs.push_back(q(mk($sformatf("d_fill%0d", i), 1, 32'h1000 + 32'(16 * i), 0, 0, 0, 0, 0),
                          0, i == 7, 0));
      vecs.push_back(q(mk("d_overflow", 1, 32'h2000, 0, 0, 0, 0, 0), 0, 1, 1));
      vecs.push_back(q(u(mk("d_fullswap", 1, 32'h1080, 0, 0, 1, 0, 0), 32'h1000, 0, 0, 0), 0, 1, 1));
      for (int i = 1; i <= 8; i++)
         vecs.push_back(q(u(mk($sformatf("d_drain%0d", i), 0, 0, 0, 0, 1, 0, 0),
                            32'h1000 + 32'(16 * i), 0, 0, 0), i == 8, 0, 1));
      // Resolve on empty: ignored, sticky error; enqueue alongside is still taken.
      vecs.push_back(rst_vec("e_reset"));
      vecs.push_back(q(mk("e_res_empty", 0, 0, 0, 0, 1, 1, 32'h0), 1, 0, 1));
      vecs.push_back(q(mk("e_idle", 0, 0, 0, 0, 0, 0, 0), 1, 0, 1));
      vecs.push_back(q(mk("e_enq_res", 1, 32'h3000, 0, 0, 1, 0, 0), 0, 0, 1));
      vecs.push_back(q(u(mk("e_res", 0, 0, 0, 0, 1, 0, 0), 32'h3000, 0, 0, 0), 1, 0, 1));
      // Reset mid-operation beats a pending mispredicting resolve.
      vecs.push_back(rst_vec("f_reset"));
      vecs.push_back(q(mk("f_res_empty", 0, 0, 0, 0, 1, 0, 0), 1, 0, 1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(q(mk($sformatf("f_enq%0d", i), 1, 32'h4000 + 32'(16 * i), 0, 0, 0, 0, 0), 0, 0, 1));
      begin
         vec_t v = mk("f_reset_res", 1, 32'h4100, 0, 0, 1, 1, 32'h777);
         v.rst = 1'b1;
         vecs.push_back(q(v, 1, 0, 0));
      end
      vecs.push_back(q(mk("f_idle", 0, 0, 0, 0, 0, 0, 0), 1, 0, 0));
      vecs.push_back(q(mk("f_enq", 1, 32'h5000, 0, 0, 0, 0, 0), 0, 0, 0));
      vecs.push_back(q(u(mk("f_res", 0, 0, 0, 0, 1, 0, 0), 32'h5000, 0, 0, 0), 1, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
